stopwatch_control: RTL and testbench

Button-driven stopwatch controller that sits directly upstream of the seven-segment decoder/driver. It debounces three raw push-buttons, runs a run/pause/lap/clear state machine, and counts a two-digit BCD value (00–99) on an external 1 Hz strobe. Its 10-bit display word and load strobe connect straight to the driver's `data` and `buffer_in` inputs.

---
 rtl/stopwatch_pkg.sv | 47 ++++
 rtl/button_debounce.sv | 59 +++++
 rtl/stopwatch_control.sv | 138 +++++++++++++
 tb/tb_stopwatch_control.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared encodings and helpers for the stopwatch controller.
package stopwatch_pkg;

  // Controller state encoding.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam logic [1:0] ST_LAP   = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_RUN   = ST_RUN,
    S_PAUSE = ST_PAUSE,
    S_LAP   = ST_LAP
  } state_t;

  // Largest value a BCD digit may hold.
  localparam logic [3:0] BCD_MAX = 4'd9;

  // Display word layout expected by the seven-segment driver.
  localparam int DISP_W      = 10;
  localparam int DP_TENS_BIT = 9;
  localparam int DP_ONES_BIT = 8;
  localparam int TENS_MSB    = 7;
  localparam int TENS_LSB    = 4;
  localparam int ONES_MSB    = 3;
  localparam int ONES_LSB    = 0;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd2_t;

  // Assemble the driver word from decimal points and two digits.
  function automatic logic [DISP_W-1:0] pack_display(input logic  dp_tens,
                                                     input logic  dp_ones,
                                                     input bcd2_t digits);
    logic [DISP_W-1:0] w;
    w                    = '0;
    w[DP_TENS_BIT]       = dp_tens;
    w[DP_ONES_BIT]       = dp_ones;
    w[TENS_MSB:TENS_LSB] = digits.tens;
    w[ONES_MSB:ONES_LSB] = digits.ones;
    return w;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Synchronizes and debounces one raw push-button; emits a one-cycle pulse
// on each accepted press (releases are debounced silently).
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic level,
  output logic press
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          level_q;
  logic [CW-1:0] cnt;

  // Two-flop synchronizer for the asynchronous button input.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  // Count consecutive cycles the synced level disagrees with the accepted level.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (sync2 == level) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt   <= '0;
      level <= ~level;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Rising edge of the accepted level becomes a one-cycle press pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      level_q <= 1'b0;
      press   <= 1'b0;
    end else begin
      level_q <= level;
      press   <= level & ~level_q;
    end
  end

endmodule

// File: rtl/stopwatch_control.sv
// Stopwatch controller: debounced buttons drive a run/pause/lap/clear FSM
// and a two-digit BCD count, presented as a registered driver word.
module stopwatch_control
  import stopwatch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       btn_run,
  input  logic       btn_lap,
  input  logic       btn_clear,
  output logic [9:0] data,
  output logic       data_valid,
  output logic       running,
  output logic       lap_active
);

  logic press_run, press_lap, press_clear;
  // Accepted levels are not needed here; only the press pulses are used.
  logic [2:0] levels_unused;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_run (
    .clk(clk), .rst(rst), .btn_raw(btn_run), .level(levels_unused[0]), .press(press_run)
  );
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_lap (
    .clk(clk), .rst(rst), .btn_raw(btn_lap), .level(levels_unused[1]), .press(press_lap)
  );
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_clear (
    .clk(clk), .rst(rst), .btn_raw(btn_clear), .level(levels_unused[2]), .press(press_clear)
  );

  state_t            state_q, state_d;
  bcd2_t             cnt_q, cnt_inc, cnt_d;
  bcd2_t             snap_q, snap_d;
  bcd2_t             shown;
  logic              ovf_q, ovf_inc, ovf_d;
  logic [DISP_W-1:0] data_d;
  logic              first_q;

  // Next-state, count, snapshot and display word for the coming edge.
  // NOTE: every variable gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_inc = cnt_q;
    ovf_inc = ovf_q;
    snap_d  = snap_q;

    // Count advances from the pre-transition state only.
    if (tick && (state_q == S_RUN || state_q == S_LAP)) begin
      if (cnt_q.ones == BCD_MAX) begin
        cnt_inc.ones = 4'd0;
        if (cnt_q.tens == BCD_MAX) begin
          cnt_inc.tens = 4'd0;
          ovf_inc      = 1'b1;
        end else begin
          cnt_inc.tens = cnt_q.tens + 4'd1;
        end
      end else begin
        cnt_inc.ones = cnt_q.ones + 4'd1;
      end
    end

    cnt_d = cnt_inc;
    ovf_d = ovf_inc;

    // Each branch tests only the presses that matter there, in clear > run > lap order.
    case (state_q)
      S_IDLE: begin
        if (press_run) state_d = S_RUN;
      end
      S_RUN: begin
        if (press_run) begin
          state_d = S_PAUSE;
        end else if (press_lap) begin
          state_d = S_LAP;
          snap_d  = cnt_inc;  // includes a tick landing in the same cycle
        end
      end
      S_PAUSE: begin
        if (press_clear) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end else if (press_run) begin
          state_d = S_RUN;
        end
      end
      S_LAP: begin
        if (press_run) begin
          state_d = S_PAUSE;
          snap_d  = '0;
        end else if (press_lap) begin
          state_d = S_RUN;
          snap_d  = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    shown  = (state_d == S_LAP) ? snap_d : cnt_d;
    data_d = pack_display(ovf_d, state_d == S_LAP, shown);
  end

  // Controller state, live count, overflow flag and lap snapshot.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      snap_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      snap_q  <= snap_d;
    end
  end

  // Registered outputs; data_valid flags a changed word, plus once after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      data       <= '0;
      data_valid <= 1'b0;
      running    <= 1'b0;
      lap_active <= 1'b0;
      first_q    <= 1'b1;
    end else begin
      data       <= data_d;
      data_valid <= first_q | (data_d != data);
      running    <= (state_d == S_RUN) || (state_d == S_LAP);
      lap_active <= (state_d == S_LAP);
      first_q    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stopwatch_control.sv
// Directed, table-driven bench for stopwatch_control with a short debounce window.
module tb_stopwatch_control;

  localparam int DEB = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic       btn_run;
  logic       btn_lap;
  logic       btn_clear;
  logic [9:0] data;
  logic       data_valid;
  logic       running;
  logic       lap_active;

  int errors = 0;
  int checks = 0;

  stopwatch_control #(.DEBOUNCE_CYCLES(DEB)) dut (
    .clk       (clk),
    .rst       (rst),
    .tick      (tick),
    .btn_run   (btn_run),
    .btn_lap   (btn_lap),
    .btn_clear (btn_clear),
    .data      (data),
    .data_valid(data_valid),
    .running   (running),
    .lap_active(lap_active)
  );

  always #5 clk = ~clk;

  // One vector: hold these inputs for 'cycles' edges, then expect these outputs.
  typedef struct {
    logic       run;
    logic       lap;
    logic       clr;
    logic       tck;
    int         cycles;
    logic [9:0] data;
    logic       valid;
    logic       running;
    logic       lap_act;
    string      name;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic r, input logic l, input logic c, input logic t,
                         input int n, input logic [9:0] d, input logic v,
                         input logic ru, input logic la, input string name);
    vec_t x;
    x.run = r; x.lap = l; x.clr = c; x.tck = t; x.cycles = n;
    x.data = d; x.valid = v; x.running = ru; x.lap_act = la; x.name = name;
    vecs.push_back(x);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string name, input logic [9:0] d, input logic v,
                            input logic ru, input logic la);
    check({name, ".data"}, 32'(data), 32'(d));
    check({name, ".data_valid"}, 32'(data_valid), 32'(v));
    check({name, ".running"}, 32'(running), 32'(ru));
    check({name, ".lap_active"}, 32'(lap_active), 32'(la));
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic r, input logic l, input logic c, input logic t);
    btn_run   = r;
    btn_lap   = l;
    btn_clear = c;
    tick      = t;
  endtask

  task automatic apply(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      drive(vecs[i].run, vecs[i].lap, vecs[i].clr, vecs[i].tck);
      step(vecs[i].cycles);
      check_outs(vecs[i].name, vecs[i].data, vecs[i].valid, vecs[i].running, vecs[i].lap_act);
    end
  endtask

  // Hold buttons until the press takes effect (edge DEB+4), check, then release cleanly.
  task automatic press(input logic r, input logic l, input logic c, input string name,
                       input logic [9:0] d, input logic v, input logic ru, input logic la);
    drive(r, l, c, 1'b0);
    step(DEB + 4);
    check_outs(name, d, v, ru, la);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    step(DEB + 2);
    check_outs({name, "_settled"}, d, 1'b0, ru, la);
  endtask

  function automatic logic [9:0] disp(input int n, input logic ovf, input logic lap);
    logic [3:0] t;
    logic [3:0] o;
    t = 4'(n / 10);
    o = 4'(n % 10);
    return {ovf, lap, t, o};
  endfunction

  initial begin
    // Scenario 1: run press latency.
    add_vec(1, 0, 0, 0, 7, 10'h000, 0, 0, 0, "run_hold_7");
    add_vec(1, 0, 0, 0, 1, 10'h000, 0, 1, 0, "run_edge_8");
    add_vec(1, 0, 0, 0, 2, 10'h000, 0, 1, 0, "run_hold_10");
    add_vec(0, 0, 0, 0, 6, 10'h000, 0, 1, 0, "run_release");
    // Scenario 3: lap freeze at 05 with coincident tick, then release.
    add_vec(0, 1, 0, 0, 7, 10'h005, 0, 1, 0, "lap_hold_7");
    add_vec(0, 1, 0, 1, 1, 10'h106, 1, 1, 1, "lap_enter_tick");
    add_vec(0, 1, 0, 0, 2, 10'h106, 0, 1, 1, "lap_held");
    add_vec(0, 0, 0, 0, 6, 10'h106, 0, 1, 1, "lap_release");
    add_vec(0, 0, 0, 1, 1, 10'h106, 0, 1, 1, "lap_frozen_t7");
    add_vec(0, 0, 0, 1, 1, 10'h106, 0, 1, 1, "lap_frozen_t8");
    add_vec(0, 0, 0, 1, 1, 10'h106, 0, 1, 1, "lap_frozen_t9");
    add_vec(0, 1, 0, 0, 7, 10'h106, 0, 1, 1, "lap2_hold_7");
    add_vec(0, 1, 0, 0, 1, 10'h009, 1, 1, 0, "lap_exit_live");
    add_vec(0, 0, 0, 0, 6, 10'h009, 0, 1, 0, "lap_exit_release");

    // Reset state.
    rst = 1'b1;
    drive(0, 0, 0, 0);
    step(3);
    check_outs("reset", 10'h000, 0, 0, 0);
    rst = 1'b0;
    step(1);
    check_outs("post_reset_pulse", 10'h000, 1, 0, 0);
    step(1);
    check_outs("idle_quiet", 10'h000, 0, 0, 0);

    // Scenario 1: start, then 12 ticks with one data_valid each.
    apply(0, 3);
    for (int i = 1; i <= 12; i++) begin
      drive(0, 0, 0, 1);
      step(1);
      check_outs($sformatf("tick_%0d", i), disp(i, 0, 0), 1, 1, 0);
      drive(0, 0, 0, 0);
      step(1);
      check_outs($sformatf("gap_%0d", i), disp(i, 0, 0), 0, 1, 0);
    end

    // Scenario 2: run up to 98, wrap to 00 with overflow, pause, clear.
    for (int i = 13; i <= 98; i++) begin
      drive(0, 0, 0, 1);
      step(1);
    end
    drive(0, 0, 0, 0);
    step(1);
    check_outs("at_98", disp(98, 0, 0), 0, 1, 0);
    drive(0, 0, 0, 1);
    step(1);
    check_outs("at_99", disp(99, 0, 0), 1, 1, 0);
    step(1);
    check_outs("wrap_00", 10'h200, 1, 1, 0);
    drive(0, 0, 0, 0);
    step(1);
    press(1, 0, 0, "pause_wrap", 10'h200, 0, 0, 0);
    press(0, 0, 1, "clear", 10'h000, 1, 0, 0);

    // Scenario 3: restart, count to 05, lap table.
    press(1, 0, 0, "restart", 10'h000, 0, 1, 0);
    for (int i = 1; i <= 5; i++) begin
      drive(0, 0, 0, 1);
      step(1);
    end
    apply(4, 13);

    // Scenario 5: run and clear together in PAUSE -> clear wins.
    press(1, 0, 0, "pause_09", 10'h009, 0, 0, 0);
    press(1, 0, 1, "run_clear", 10'h000, 1, 0, 0);
    step(10);
    check_outs("run_clear_idle", 10'h000, 0, 0, 0);

    // Scenario 4: bouncing run button produces one press only.
    for (int k = 0; k < 2; k++) begin
      drive(1, 0, 0, 0);
      step(2);
      drive(0, 0, 0, 0);
      step(2);
    end
    check_outs("bounce_no_press", 10'h000, 0, 0, 0);
    drive(1, 0, 0, 0);
    step(DEB + 3);
    check_outs("bounce_hold_7", 10'h000, 0, 0, 0);
    step(1);
    check_outs("bounce_hold_8", 10'h000, 0, 1, 0);
    step(4);
    drive(0, 0, 0, 0);
    step(DEB + 12);
    check_outs("bounce_single", 10'h000, 0, 1, 0);

    // Scenario 6: reset during RUN at 37 with lap held.
    for (int i = 1; i <= 37; i++) begin
      drive(0, 0, 0, 1);
      step(1);
    end
    drive(0, 0, 0, 0);
    step(1);
    check_outs("at_37", disp(37, 0, 0), 0, 1, 0);
    drive(0, 1, 0, 0);
    step(3);
    rst = 1'b1;
    step(1);
    check_outs("mid_reset", 10'h000, 0, 0, 0);
    step(2);
    rst = 1'b0;
    step(1);
    check_outs("rerelease_pulse", 10'h000, 1, 0, 0);
    step(DEB + 8);
    check_outs("lap_ignored_idle", 10'h000, 0, 0, 0);
    drive(0, 0, 0, 0);
    step(DEB + 2);

    // Tick with no press in IDLE changes nothing.
    drive(0, 0, 0, 1);
    step(1);
    check_outs("tick_idle", 10'h000, 0, 0, 0);
    drive(0, 0, 0, 0);
    step(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
